// File: rtl/hpdcache_refill_tx_pkg.sv
// Shared defaults, serializer state encoding and width helper for the refill transmitter.
package hpdcache_refill_tx_pkg;

   localparam int PARAM_CL_WORDS   = 8;
   localparam int PARAM_WORD_WIDTH = 64;

   localparam int DEF_CL_WIDTH   = PARAM_CL_WORDS * PARAM_WORD_WIDTH;
   localparam int DEF_BEAT_WIDTH = 64;
   localparam int DEF_ID_WIDTH   = 7;
   localparam int DEF_FIFO_DEPTH = 2;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } txState_e;

   // Index width for n items, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hpdcache_refill_tx_if.sv
// Line-response input side and refill-beat output side of the refill transmitter.
interface hpdcache_refill_tx_if
   import hpdcache_refill_tx_pkg::*;
#(
   parameter int CL_WIDTH   = DEF_CL_WIDTH,
   parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH
);
   localparam int BEATS = CL_WIDTH / BEAT_WIDTH;
   localparam int LEN_W = cntWidth(BEATS);

   logic                  line_valid;
   logic                  line_ready;
   logic [ID_WIDTH-1:0]   line_id;
   logic                  line_err;
   logic [LEN_W-1:0]      line_len;
   logic [CL_WIDTH-1:0]   line_data;

   logic                  beat_valid;
   logic                  beat_ready;
   logic [ID_WIDTH-1:0]   beat_id;
   logic                  beat_err;
   logic                  beat_last;
   logic [BEAT_WIDTH-1:0] beat_data;

   modport slave (
      input  line_valid, line_id, line_err, line_len, line_data, beat_ready,
      output line_ready, beat_valid, beat_id, beat_err, beat_last, beat_data
   );

   modport master (
      output line_valid, line_id, line_err, line_len, line_data, beat_ready,
      input  line_ready, beat_valid, beat_id, beat_err, beat_last, beat_data
   );

endinterface

// File: rtl/hpdcache_refill_tx_fifo.sv
// Register FIFO without feedthrough: full/empty are registered, so a freed slot
// becomes visible to the writer only on the cycle after the pop.
module hpdcache_refill_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   input  logic             i_pop,
   output logic             o_empty,
   output logic             o_single,
   output logic [WIDTH-1:0] o_data
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0] r_count, w_countNext;
   logic             r_full, r_empty;
   logic             w_push, w_pop;

   assign w_push   = i_push & ~r_full;
   assign w_pop    = i_pop & ~r_empty;
   assign o_full   = r_full;
   assign o_empty  = r_empty;
   assign o_single = (r_count == CNT_W'(1));
   assign o_data   = r_mem[r_rptr];

   always_comb begin
      w_countNext = r_count;
      if (w_push && !w_pop) begin
         w_countNext = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_countNext = r_count - CNT_W'(1);
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
         end
         r_count <= w_countNext;
         r_full  <= (w_countNext == CNT_W'(DEPTH));
         r_empty <= (w_countNext == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

endmodule

// File: rtl/hpdcache_refill_tx.sv
// Queues whole-line refill responses and serializes each into BEAT_WIDTH beats
// carrying id, error and last flags toward the HPDcache refill handler.
module hpdcache_refill_tx
   import hpdcache_refill_tx_pkg::*;
#(
   parameter int CL_WIDTH   = DEF_CL_WIDTH,
   parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
   input logic                 clk_i,
   input logic                 rst_i,
   hpdcache_refill_tx_if.slave io_refill
);
   localparam int BEATS = CL_WIDTH / BEAT_WIDTH;
   localparam int LEN_W = cntWidth(BEATS);

   if (((CL_WIDTH % BEAT_WIDTH) != 0) || (FIFO_DEPTH < 1)) begin : g_badParams
      $error("hpdcache_refill_tx: CL_WIDTH must be a multiple of BEAT_WIDTH and FIFO_DEPTH >= 1");
   end

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic                err;
      logic [LEN_W-1:0]    len;
      logic [CL_WIDTH-1:0] data;
   } refillLine_t;

   refillLine_t                      w_pushLine, w_head;
   logic                             w_full, w_empty, w_single;
   logic                             w_fire, w_last, w_pop;
   logic [LEN_W-1:0]                 r_cnt, w_cntNext;
   logic [BEATS-1:0][BEAT_WIDTH-1:0] w_beats;
   txState_e                         r_state, w_stateNext;

   assign w_pushLine = '{id:   io_refill.line_id,
                         err:  io_refill.line_err,
                         len:  io_refill.line_len,
                         data: io_refill.line_data};

   hpdcache_refill_tx_fifo #(
      .WIDTH ($bits(refillLine_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_push   (io_refill.line_valid),
      .i_data   (w_pushLine),
      .o_full   (w_full),
      .i_pop    (w_pop),
      .o_empty  (w_empty),
      .o_single (w_single),
      .o_data   (w_head)
   );

   // The head entry and counter only change on an accepted beat, which keeps the
   // beat stable under backpressure; valid comes from registered state only.
   assign w_beats               = w_head.data;
   assign w_last                = (r_cnt == w_head.len);
   assign w_fire                = ~w_empty & io_refill.beat_ready;
   assign io_refill.line_ready  = ~w_full;
   assign io_refill.beat_valid  = ~w_empty;
   assign io_refill.beat_id     = w_head.id;
   assign io_refill.beat_err    = w_head.err;
   assign io_refill.beat_last   = ~w_empty & w_last;
   assign io_refill.beat_data   = w_beats[r_cnt];

   // A line is presented as soon as it lands in the queue, so the beat path is
   // driven from the queue head in both states to reach beat 0 one cycle after push.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_pop       = 1'b0;
      if (w_fire) begin
         if (w_last) begin
            w_pop     = 1'b1;
            w_cntNext = '0;
         end else begin
            w_cntNext = r_cnt + LEN_W'(1);
         end
      end
      case (r_state)
         TX_IDLE: if (!w_empty && !(w_pop && w_single)) w_stateNext = TX_SEND;
         TX_SEND: if (w_pop && w_single)                w_stateNext = TX_IDLE;
         default: w_stateNext = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= TX_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

endmodule

// File: tb/tb_hpdcache_refill_tx.sv
// Directed self-checking bench for hpdcache_refill_tx with hand-computed beat expectations.
module tb_hpdcache_refill_tx;

   localparam int CL_WIDTH   = 512;
   localparam int BEAT_WIDTH = 64;
   localparam int ID_WIDTH   = 7;
   localparam int FIFO_DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nChecks = 0;
   int   nPass   = 0;

   always #5 clk = ~clk;

   hpdcache_refill_tx_if #(
      .CL_WIDTH   (CL_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
   ) refillIf ();

   hpdcache_refill_tx #(
      .CL_WIDTH   (CL_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .io_refill (refillIf)
   );

   // Builds a line whose beat i holds base+i.
   function automatic logic [CL_WIDTH-1:0] makeLine(input logic [63:0] base);
      logic [CL_WIDTH-1:0] d;
      for (int i = 0; i < CL_WIDTH / 64; i++) d[i*64 +: 64] = base + 64'(i);
      return d;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      else nPass++;
   endtask

   task automatic applyStimulus(input logic [6:0] id, input logic err, input logic [2:0] len,
                                input logic [CL_WIDTH-1:0] data);
      refillIf.line_valid = 1'b1;
      refillIf.line_id    = id;
      refillIf.line_err   = err;
      refillIf.line_len   = len;
      refillIf.line_data  = data;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBeat(input string tag, input logic [6:0] id, input logic [63:0] data,
                            input logic last);
      checkOutput({tag, "_valid"}, 64'(refillIf.beat_valid), 64'(1));
      checkOutput({tag, "_id"},    64'(refillIf.beat_id),    64'(id));
      checkOutput({tag, "_data"},  refillIf.beat_data,       data);
      checkOutput({tag, "_last"},  64'(refillIf.beat_last),  64'(last));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CL_WIDTH-1:0] line;
      logic [6:0]  expId   [5];
      logic [63:0] expData [5];
      logic        expLast [5];
      logic        readyPat [6];
      int          idx;

      refillIf.line_valid = 1'b0;
      refillIf.line_id    = '0;
      refillIf.line_err   = 1'b0;
      refillIf.line_len   = '0;
      refillIf.line_data  = '0;
      refillIf.beat_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_lineReady", 64'(refillIf.line_ready), 64'(1));
      checkOutput("rst_beatValid", 64'(refillIf.beat_valid), 64'(0));
      checkOutput("rst_beatLast",  64'(refillIf.beat_last),  64'(0));
      rst = 1'b0;
      nextCycle();

      // Single full line, id 0x12, 8 beats back to back
      refillIf.beat_ready = 1'b1;
      applyStimulus(7'h12, 1'b0, 3'd7, makeLine(64'hA0));
      @(negedge clk);
      checkOutput("single_noValidYet", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();
      refillIf.line_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkBeat($sformatf("single_b%0d", i), 7'h12, 64'hA0 + 64'(i), i == 7);
         checkOutput($sformatf("single_b%0d_err", i), 64'(refillIf.beat_err), 64'(0));
         nextCycle();
      end
      @(negedge clk);
      checkOutput("single_idle", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();

      // Uncached single beat with error
      line = makeLine(64'h1000);
      line[63:0] = 64'hDEADBEEF_CAFEF00D;
      applyStimulus(7'h05, 1'b1, 3'd0, line);
      nextCycle();
      refillIf.line_valid = 1'b0;
      @(negedge clk);
      checkBeat("unc", 7'h05, 64'hDEADBEEF_CAFEF00D, 1'b1);
      checkOutput("unc_err", 64'(refillIf.beat_err), 64'(1));
      nextCycle();
      @(negedge clk);
      checkOutput("unc_idle", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();

      // Backpressure: held beat must stay identical
      applyStimulus(7'h33, 1'b0, 3'd3, makeLine(64'h100));
      nextCycle();
      refillIf.line_valid = 1'b0;
      readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         refillIf.beat_ready = readyPat[c];
         @(negedge clk);
         checkBeat($sformatf("bp_c%0d", c), 7'h33, 64'h100 + 64'(idx), idx == 3);
         if (readyPat[c]) idx++;
         nextCycle();
      end
      @(negedge clk);
      checkOutput("bp_idle", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();

      // Queue full: three pushes with the refill side stalled
      refillIf.beat_ready = 1'b0;
      applyStimulus(7'h01, 1'b0, 3'd1, makeLine(64'h200));
      @(negedge clk);
      checkOutput("qf_readyA", 64'(refillIf.line_ready), 64'(1));
      nextCycle();
      applyStimulus(7'h02, 1'b0, 3'd1, makeLine(64'h300));
      @(negedge clk);
      checkOutput("qf_readyB", 64'(refillIf.line_ready), 64'(1));
      nextCycle();
      applyStimulus(7'h03, 1'b0, 3'd0, makeLine(64'h400));
      @(negedge clk);
      checkOutput("qf_full", 64'(refillIf.line_ready), 64'(0));
      checkBeat("qf_stall", 7'h01, 64'h200, 1'b0);
      nextCycle();
      refillIf.beat_ready = 1'b1;
      expId   = '{7'h01, 7'h01, 7'h02, 7'h02, 7'h03};
      expData = '{64'h200, 64'h201, 64'h300, 64'h301, 64'h400};
      expLast = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkBeat($sformatf("qf_k%0d", k), expId[k], expData[k], expLast[k]);
         if (k == 1) checkOutput("qf_fullAtPop", 64'(refillIf.line_ready), 64'(0));
         if (k == 2) checkOutput("qf_freed",     64'(refillIf.line_ready), 64'(1));
         nextCycle();
         if (k == 2) refillIf.line_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput("qf_idle", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();

      // Reset mid-line drops the partial line and the queued one
      applyStimulus(7'h44, 1'b0, 3'd7, makeLine(64'h500));
      nextCycle();
      applyStimulus(7'h45, 1'b0, 3'd7, makeLine(64'h700));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("mid_b%0d", i), refillIf.beat_data, 64'h500 + 64'(i));
         nextCycle();
         refillIf.line_valid = 1'b0;
      end
      rst = 1'b1;
      #1;
      checkOutput("mid_rstValid", 64'(refillIf.beat_valid), 64'(0));
      checkOutput("mid_rstReady", 64'(refillIf.line_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      nextCycle();
      @(negedge clk);
      checkOutput("mid_dropped", 64'(refillIf.beat_valid), 64'(0));
      nextCycle();
      applyStimulus(7'h46, 1'b0, 3'd1, makeLine(64'h600));
      nextCycle();
      refillIf.line_valid = 1'b0;
      @(negedge clk);
      checkBeat("post_b0", 7'h46, 64'h600, 1'b0);
      nextCycle();
      @(negedge clk);
      checkBeat("post_b1", 7'h46, 64'h601, 1'b1);
      nextCycle();
      @(negedge clk);
      checkOutput("post_idle", 64'(refillIf.beat_valid), 64'(0));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
